// File: rtl/wb_port_arbiter_pkg.sv
// Shared CPU write-back constants and payload types used by the register-file
// write-port arbiter and its mul/div result buffer.
package wb_port_arbiter_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned REG_AW        = 5;
    localparam int unsigned NUM_REGS      = 32;
    localparam int unsigned MD_FIFO_DEPTH = 2;
    localparam int unsigned MD_CNT_W      = 2;
    localparam int unsigned STARVE_CNT_W  = 4;

    localparam logic [REG_AW-1:0]       REG_X0     = '0;
    localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = '1;

    // Which producer owns the register-file write port this cycle
    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_PIPE = 2'd1,
        WB_SRC_MD   = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_write_t;

    typedef struct packed {
        logic      valid;
        wb_write_t wr;
    } md_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle between the pipeline / mul-div unit and the arbiter.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic                pipe_we_i;
    logic [REG_AW-1:0]   pipe_rd_i;
    logic [XLEN-1:0]     pipe_wdata_i;
    logic                md_valid_i;
    logic [REG_AW-1:0]   md_rd_i;
    logic [XLEN-1:0]     md_wdata_i;
    logic                md_ready_o;
    logic                stall_o;
    logic                rf_we_o;
    logic [REG_AW-1:0]   rf_waddr_o;
    logic [XLEN-1:0]     rf_wdata_o;
    logic [NUM_REGS-1:0] pending_o;

    modport slave (
        input  pipe_we_i, pipe_rd_i, pipe_wdata_i,
        input  md_valid_i, md_rd_i, md_wdata_i,
        output md_ready_o, stall_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o, pending_o
    );

    modport master (
        output pipe_we_i, pipe_rd_i, pipe_wdata_i,
        output md_valid_i, md_rd_i, md_wdata_i,
        input  md_ready_o, stall_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o, pending_o
    );

endinterface

// File: rtl/wb_md_fifo.sv
// Two-entry in-order buffer for mul/div results; entries can be invalidated by
// destination register when a younger pipeline write to the same rd commits.
module wb_md_fifo
    import wb_port_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enq,
    input  wb_write_t           enq_wr,
    input  logic                pop,
    input  logic                kill,
    input  logic [REG_AW-1:0]   kill_rd,
    output logic                occupied_c,
    output logic                full_c,
    output md_entry_t           head_c,
    output logic [NUM_REGS-1:0] pending_c
);

    md_entry_t            ent_q [MD_FIFO_DEPTH];
    md_entry_t            ent_d [MD_FIFO_DEPTH];
    logic [MD_CNT_W-1:0]  cnt_q;
    logic [MD_CNT_W-1:0]  cnt_d;

    // Kill applies to resident entries only, then pop shifts, then enqueue lands behind
    always_comb begin
        ent_d = ent_q;
        cnt_d = cnt_q;
        for (int i = 0; i < MD_FIFO_DEPTH; i++) begin
            if (kill && ent_q[i].valid && (ent_q[i].wr.rd == kill_rd)) begin
                ent_d[i].valid = 1'b0;
            end
        end
        if (pop) begin
            for (int i = 0; i < MD_FIFO_DEPTH - 1; i++) begin
                ent_d[i] = ent_d[i+1];
            end
            ent_d[MD_FIFO_DEPTH-1] = '0;
            cnt_d = cnt_q - MD_CNT_W'(1);
        end
        if (enq) begin
            for (int i = 0; i < MD_FIFO_DEPTH; i++) begin
                if (MD_CNT_W'(i) == cnt_d) begin
                    ent_d[i] = '{valid: 1'b1, wr: enq_wr};
                end
            end
            cnt_d = cnt_d + MD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign occupied_c = (cnt_q != '0);
    assign full_c     = (cnt_q == MD_CNT_W'(MD_FIFO_DEPTH));
    assign head_c     = ent_q[0];

    // Destination mask of live buffered results, decoded from registered state only
    always_comb begin
        pending_c = '0;
        for (int i = 0; i < MD_FIFO_DEPTH; i++) begin
            if (ent_q[i].valid) begin
                pending_c[ent_q[i].wr.rd] = 1'b1;
            end
        end
        pending_c[REG_X0] = 1'b0;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the in-order pipeline write-back and
// buffered multi-cycle mul/div results, with starvation-driven pipeline stall.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_port_arbiter_if.slave  bus
);

    logic                    occupied_c;
    logic                    full_c;
    md_entry_t               head_c;
    logic [NUM_REGS-1:0]     pending_c;
    logic                    stall_c;
    logic                    pipe_grant_c;
    logic                    head_grant_c;
    logic                    drain_c;
    logic                    ready_c;
    logic                    enq_c;
    wb_src_e                 src_c;
    logic [STARVE_CNT_W-1:0] starve_q;
    logic [STARVE_CNT_W-1:0] starve_d;
    logic                    rf_we_q;
    logic [REG_AW-1:0]       rf_waddr_q;
    logic [XLEN-1:0]         rf_wdata_q;

    wb_md_fifo u_md_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .enq        (enq_c),
        .enq_wr     ('{rd: bus.md_rd_i, data: bus.md_wdata_i}),
        .pop        (drain_c),
        .kill       (pipe_grant_c),
        .kill_rd    (bus.pipe_rd_i),
        .occupied_c (occupied_c),
        .full_c     (full_c),
        .head_c     (head_c),
        .pending_c  (pending_c)
    );

    // Grant, drain and acceptance; a dead head pops without using the port
    always_comb begin
        stall_c      = occupied_c &&
                       ((starve_q >= STARVE_CNT_W'(STARVE_LIMIT)) || (full_c && bus.md_valid_i));
        pipe_grant_c = bus.pipe_we_i && (bus.pipe_rd_i != REG_X0) && !stall_c;
        head_grant_c = !pipe_grant_c && occupied_c && head_c.valid;
        drain_c      = occupied_c && (head_grant_c || !head_c.valid);
        ready_c      = !full_c || drain_c;
        enq_c        = bus.md_valid_i && ready_c && (bus.md_rd_i != REG_X0);
        src_c        = pipe_grant_c ? WB_SRC_PIPE : (head_grant_c ? WB_SRC_MD : WB_SRC_NONE);
        starve_d     = '0;
        if (occupied_c && !drain_c) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            starve_q <= starve_d;
            rf_we_q  <= (src_c != WB_SRC_NONE);
            case (src_c)
                WB_SRC_PIPE: begin
                    rf_waddr_q <= bus.pipe_rd_i;
                    rf_wdata_q <= bus.pipe_wdata_i;
                end
                WB_SRC_MD: begin
                    rf_waddr_q <= head_c.wr.rd;
                    rf_wdata_q <= head_c.wr.data;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.md_ready_o = ready_c;
    assign bus.stall_o    = stall_c;
    assign bus.rf_we_o    = rf_we_q;
    assign bus.rf_waddr_o = rf_waddr_q;
    assign bus.rf_wdata_o = rf_wdata_q;
    assign bus.pending_o  = pending_c;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts
// every cycle's write-back, and a monitor compares after each rising edge.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int LIMIT = 4;

    typedef struct { int rd; int unsigned data; bit live; } md_t;
    typedef struct { bit we; int addr; int unsigned data; bit [31:0] pend; } exp_t;
    typedef struct { int addr; int unsigned data; } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_port_arbiter_if bus();
    wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    md_t         mq[$];
    exp_t        exp_q[$];
    wr_t         wr_log[$];
    int          starve = 0;
    int          held_addr = 0;
    int unsigned held_data = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    bit          rst_drv = 1'b0;
    bit          last_stall = 1'b0;
    bit          last_ready = 1'b1;
    int          rd_pool[8] = '{0, 1, 2, 3, 5, 7, 9, 9};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: FIFO as a queue of results with a liveness flag, rules applied in order
    task automatic model_step(input bit pw, input int prd, input int unsigned pd,
                              input bit mv, input int mrd, input int unsigned md,
                              output bit stall, output bit ready);
        bit occ, pipe_win, head_live, head_win, pop;
        bit [31:0] p;
        exp_t e;
        if (!rst_drv) begin
            mq.delete();
            starve = 0; held_addr = 0; held_data = 0;
            stall = 1'b0; ready = 1'b1;
            e = '{we: 1'b0, addr: 0, data: 0, pend: 0};
            exp_q.push_back(e);
            return;
        end
        occ       = (mq.size() > 0);
        stall     = occ && ((starve >= LIMIT) || (mq.size() == 2 && mv));
        pipe_win  = pw && (prd != 0) && !stall;
        head_live = occ && mq[0].live;
        head_win  = !pipe_win && head_live;
        pop       = occ && (head_win || !mq[0].live);
        ready     = (mq.size() < 2) || pop;
        e.we = pipe_win || head_win;
        if (pipe_win) begin held_addr = prd; held_data = pd; end
        else if (head_win) begin held_addr = mq[0].rd; held_data = mq[0].data; end
        e.addr = held_addr; e.data = held_data;
        if (pipe_win) foreach (mq[i]) if (mq[i].rd == prd) mq[i].live = 1'b0;
        if (pop) void'(mq.pop_front());
        if (mv && ready && mrd != 0) mq.push_back('{rd: mrd, data: md, live: 1'b1});
        starve = (occ && !pop) ? ((starve >= 15) ? 15 : starve + 1) : 0;
        p = '0;
        foreach (mq[i]) if (mq[i].live) p[mq[i].rd] = 1'b1;
        p[0] = 1'b0;
        e.pend = p;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit pw, input int prd, input int unsigned pd,
                         input bit mv, input int mrd, input int unsigned md);
        bit s, r;
        @(negedge clk);
        rst_n            = rst_drv;
        bus.pipe_we_i    = pw;
        bus.pipe_rd_i    = 5'(prd);
        bus.pipe_wdata_i = pd;
        bus.md_valid_i   = mv;
        bus.md_rd_i      = 5'(mrd);
        bus.md_wdata_i   = md;
        #1;
        model_step(pw, prd, pd, mv, mrd, md, s, r);
        chk("stall_o", bus.stall_o, s);
        chk("md_ready_o", bus.md_ready_o, r);
        last_stall = s;
        last_ready = r;
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    function automatic int count_writes(input int from, input int rd, input int unsigned data,
                                        input bit match_data);
        int n = 0;
        for (int i = from; i < wr_log.size(); i++)
            if (wr_log[i].addr == rd && (!match_data || wr_log[i].data == data)) n++;
        return n;
    endfunction

    // Monitor: one expectation per rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_we_o", bus.rf_we_o, e.we);
                    chk("rf_waddr_o", bus.rf_waddr_o, e.addr);
                    chk("rf_wdata_o", bus.rf_wdata_o, e.data);
                    chk("pending_o", bus.pending_o, e.pend);
                    if (bus.rf_we_o === 1'b1)
                        wr_log.push_back('{addr: int'(bus.rf_waddr_o), data: bus.rf_wdata_o});
                end
            end
        end
    end

    initial begin
        int          stall_at;
        int          mark;
        int unsigned pd;
        bit          pw, mv;
        int          prd, mrd;
        int unsigned pdat, mdat;

        bus.pipe_we_i = 1'b0; bus.pipe_rd_i = '0; bus.pipe_wdata_i = '0;
        bus.md_valid_i = 1'b0; bus.md_rd_i = '0; bus.md_wdata_i = '0;

        // Reset state
        rst_drv = 1'b0;
        idle(2);
        chk("rst_rf_we", bus.rf_we_o, 0);
        chk("rst_pending", bus.pending_o, 0);
        rst_drv = 1'b1;
        idle(1);

        // Idle FIFO: pipeline write goes straight through
        cycle(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 0);
        idle(1);
        chk("idle_addr", wr_log[wr_log.size()-1].addr, 5);
        chk("idle_data", wr_log[wr_log.size()-1].data, 32'hDEADBEEF);

        // Contention: starved md result forces a stall, then the held pipe write follows
        stall_at = -1;
        pd = 32'h100;
        cycle(1'b1, 3, pd, 1'b1, 7, 32'h12);
        for (int i = 1; i < 12; i++) begin
            if (!last_stall) pd = pd + 1;
            cycle(1'b1, 3, pd, 1'b0, 0, 0);
            if (last_stall && stall_at < 0) stall_at = i;
            else if (stall_at >= 0) break;
        end
        idle(2);
        chk("starve_delay", stall_at, LIMIT + 1);
        chk("starve_md_addr", wr_log[wr_log.size()-2].addr, 7);
        chk("starve_md_data", wr_log[wr_log.size()-2].data, 32'h12);
        chk("held_pipe_addr", wr_log[wr_log.size()-1].addr, 3);
        chk("held_pipe_data", wr_log[wr_log.size()-1].data, 32'h105);

        // Kill: younger pipeline write to rd 9 invalidates the buffered md result
        mark = wr_log.size();
        cycle(1'b1, 4, 32'hB, 1'b1, 9, 32'h99);
        cycle(1'b1, 9, 32'hA, 1'b0, 0, 0);
        chk("kill_pending_before", bus.pending_o[9], 1);
        idle(1);
        chk("kill_pending_after", bus.pending_o[9], 0);
        idle(3);
        chk("kill_rd9_writes", count_writes(mark, 9, 0, 1'b0), 1);
        chk("kill_rd9_value", count_writes(mark, 9, 32'hA, 1'b1), 1);

        // Full FIFO with a third offer: stall, drain and accept in the same cycle
        mark = wr_log.size();
        cycle(1'b1, 4, 1, 1'b1, 10, 32'h10);
        cycle(1'b1, 4, 2, 1'b1, 11, 32'h11);
        cycle(1'b1, 4, 3, 1'b1, 12, 32'h12);
        chk("full_stall", bus.stall_o, 1);
        chk("full_ready", bus.md_ready_o, 1);
        cycle(1'b1, 4, 3, 1'b0, 0, 0);
        idle(4);
        chk("full_rd10", count_writes(mark, 10, 32'h10, 1'b1), 1);
        chk("full_rd11", count_writes(mark, 11, 32'h11, 1'b1), 1);
        chk("full_rd12", count_writes(mark, 12, 32'h12, 1'b1), 1);

        // x0 from both sources
        cycle(1'b1, 0, 32'h55, 1'b1, 0, 32'h66);
        idle(1);
        chk("x0_we", bus.rf_we_o, 0);
        chk("x0_pending", bus.pending_o, 0);

        // Reset mid-operation with two buffered results
        cycle(1'b1, 4, 1, 1'b1, 13, 32'h13);
        cycle(1'b1, 4, 2, 1'b1, 14, 32'h14);
        rst_drv = 1'b0;
        cycle(1'b1, 4, 3, 1'b1, 15, 32'h15);
        chk("midrst_we", bus.rf_we_o, 0);
        chk("midrst_waddr", bus.rf_waddr_o, 0);
        chk("midrst_wdata", bus.rf_wdata_o, 0);
        chk("midrst_pending", bus.pending_o, 0);
        rst_drv = 1'b1;
        mark = wr_log.size();
        idle(4);
        chk("midrst_no_write", wr_log.size() - mark, 0);

        // Randomized traffic; pipeline holds while stalled, md holds until accepted
        pw = 1'b0; prd = 0; pdat = 0; mv = 1'b0; mrd = 0; mdat = 0;
        last_stall = 1'b0; last_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                pw   = ($urandom_range(0, 99) < 70);
                prd  = rd_pool[$urandom_range(0, 7)];
                pdat = $urandom;
            end
            if (!(mv && !last_ready)) begin
                mv   = ($urandom_range(0, 99) < 35);
                mrd  = rd_pool[$urandom_range(0, 7)];
                mdat = $urandom;
            end
            cycle(pw, prd, pdat, mv, mrd, mdat);
        end
        idle(6);
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
